pipeline_hazard_tracker: RTL and testbench
==========================================

# pipeline_hazard_tracker

Parametrised hazard-detection and forwarding-select unit for the in-order pipeline. It replaces the fixed three-destination-register comparison with an internal shadow pipeline of in-flight destination records, DEPTH stages deep. It adds a memory-wait freeze, kill handling, optional hard-wired R0 and a saturating stall counter. It sits beside the ID stage: it consumes the decoded ID instruction and drives the stall and the ForwardA/ForwardB selects for the ID operand muxes.

## Interface
- REG_ADDR_W, 3: register address width.
- DEPTH, 3: tracked stages after ID (1=EXE, 2=MEM, 3=WB, ...); legal range 1-7.
- LOAD_READY, 2: lowest stage index whose load result is forwardable; 1 ≤ LOAD_READY ≤ DEPTH.
- ZERO_REG_HARD, 0: 1 = register 0 never matches (no stall, no forward).
- CNT_W, 16: stall counter width.
- FW = $clog2(DEPTH+1): width of the forward selects.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  REG_ADDR_W  destination register
- id_reg_wr  in  1  instruction writes id_rd
- id_mem_rd  in  1  instruction is a load
- kill  in  1  ID instruction squashed (taken branch/jump)
- mem_wait  in  1  memory not ready; whole pipeline frozen
- stall  out  1  load-use hazard; hold IF/ID, insert bubble
- hold_id  out  1  stall | mem_wait
- fwd_a, fwd_b  out  FW  0 = register file, k = result of stage k
- inflight  out  FW  count of valid writing records
- stall_count  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Record per stage k (1..DEPTH): {v, rd, wr, ld}. Record 1 is the instruction in EXE.
- Update on clk:
  - reset: all v=0; stall_count=0.
  - else if mem_wait: all records hold.
  - else: record1 ← {1, id_rd, id_reg_wr, id_mem_rd} if id_valid & ~kill & ~stall, otherwise a bubble (v=0). Record k+1 ← record k. Record DEPTH retires.
- Match for source s: record k with v & wr & rd==s, and s≠0 when ZERO_REG_HARD. The youngest (smallest k) match wins.
- Forward select, per operand independently:
  - 0 if the source is unused, id_valid=0, or there is no match.
  - Otherwise k of the youngest match.
- Hazard: for either used source, the youngest match has ld=1 and k < LOAD_READY.
- stall = id_valid & ~kill & hazard. While stall=1, fwd_a and fwd_b still report the current match value.
- kill has priority over hazard: the instruction is dropped, stall=0, and a bubble is inserted.
- stall_count increments on an edge where stall=1 & mem_wait=0 & reset=0. It saturates at 2^CNT_W−1.
- inflight = number of records with v & wr.

## Timing
- stall, hold_id, fwd_a, fwd_b and inflight are combinational from the records and the ID inputs: valid in the same cycle, with no added latency.
- Records and stall_count change only on the clk edge.
- Reset values: all records invalid. With id_valid=0 this gives stall=0, hold_id=mem_wait, fwd_a=fwd_b=0, inflight=0, stall_count=0.
- Reset asserted mid-operation clears all records on that edge; no forward to pre-reset records afterwards.
- Load-use with LOAD_READY=2:
  - Exactly one stall cycle when the load is in stage 1.
  - The next cycle the load is in stage 2, giving fwd=2.
  - A mem_wait during the stall extends the stall without incrementing stall_count.
- A record at stage DEPTH is forwardable in its last cycle. After retiring, the register file is assumed written and fwd=0.
- Simultaneous kill & stall: kill wins (bubble, stall=0, counter unchanged).
- Simultaneous mem_wait & kill: records hold. kill is only effective for insertion on a non-waiting edge.

## Test plan
- Default parameters. ADD R2 issued, then a consumer of R2 the next cycle → fwd_a=1. One cycle later → fwd_a=2. Then → fwd_a=3. Then → fwd_a=0.
- LOAD R3 followed by a use of R3 as rs2 → stall=1 for 1 cycle, stall_count=1, then fwd_b=2. The bubble is visible: inflight does not count a bubble.
- Same load-use with mem_wait high for 3 cycles during the stall → stall held for 4 cycles, stall_count=1, records frozen.
- R5 written at stage 1 and stage 3 simultaneously → fwd_a=1 (youngest wins). Same case with rs1_used=0 → fwd_a=0.
- ZERO_REG_HARD=1: load to R0 followed by a use of R0 → stall=0, fwd=0. With ZERO_REG_HARD=0 → stall=1.
- kill during a load-use hazard → stall=0 and no record inserted. Reset mid-stream → inflight=0 next cycle. Counter with CNT_W=2 after 5 stalls → 3.

Source files
------------

// File: rtl/pipeline_hazard_tracker.sv
// rtl/pipeline_hazard_tracker.sv - load-use stall and forward-select unit beside the ID stage
//
// Tracks the destination of each in-flight instruction for DEPTH stages after ID
// and derives the ID operand forward selects and the load-use stall from them.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   id_valid             ID holds a real instruction
//   id_rs1/id_rs2        source registers, id_rs1_used/id_rs2_used: source actually read
//   id_rd, id_reg_wr     destination register and its write enable
//   id_mem_rd            ID instruction is a load
//   kill                 ID instruction squashed; a bubble is inserted instead
//   mem_wait             memory not ready; all records hold
//   stall                load-use hazard on the ID instruction
//   hold_id              stall | mem_wait
//   fwd_a/fwd_b          0 = register file, k = result of stage k
//   inflight             number of valid writing records
//   stall_count          saturating count of hazard-stall cycles
module pipeline_hazard_tracker #(
  parameter int REG_ADDR_W    = 3,
  parameter int DEPTH         = 3,
  parameter int LOAD_READY    = 2,
  parameter int ZERO_REG_HARD = 0,
  parameter int CNT_W         = 16,
  localparam int FW           = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_wr,
  input  logic                  id_mem_rd,
  input  logic                  kill,
  input  logic                  mem_wait,
  output logic                  stall,
  output logic                  hold_id,
  output logic [FW-1:0]         fwd_a,
  output logic [FW-1:0]         fwd_b,
  output logic [FW-1:0]         inflight,
  output logic [CNT_W-1:0]      stall_count
);

  // Stage k of the shadow pipeline lives at index k (1 = EXE).
  logic [DEPTH:1]          v_q, v_d;
  logic [DEPTH:1]          wr_q, wr_d;
  logic [DEPTH:1]          ld_q, ld_d;
  logic [REG_ADDR_W-1:0]   rd_q [1:DEPTH];
  logic [REG_ADDR_W-1:0]   rd_d [1:DEPTH];
  logic [CNT_W-1:0]        stall_count_q, stall_count_d;

  logic [FW-1:0] sel_a, sel_b;
  logic          haz_a, haz_b;
  logic          hazard;
  logic [FW-1:0] inflight_cnt;

  // Scan from oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (v_q[k] && wr_q[k] && (rd_q[k] == id_rs1) &&
          !((ZERO_REG_HARD != 0) && (id_rs1 == '0))) begin
        sel_a = FW'(k);
        haz_a = ld_q[k] && (k < LOAD_READY);
      end
      if (v_q[k] && wr_q[k] && (rd_q[k] == id_rs2) &&
          !((ZERO_REG_HARD != 0) && (id_rs2 == '0))) begin
        sel_b = FW'(k);
        haz_b = ld_q[k] && (k < LOAD_READY);
      end
    end
  end

  always_comb begin
    inflight_cnt = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      inflight_cnt = inflight_cnt + FW'(v_q[k] & wr_q[k]);
    end
  end

  // kill outranks the hazard: a squashed instruction never stalls.
  assign hazard      = (id_rs1_used & haz_a) | (id_rs2_used & haz_b);
  assign stall       = id_valid & ~kill & hazard;
  assign hold_id     = stall | mem_wait;
  assign fwd_a       = (id_valid && id_rs1_used) ? sel_a : '0;
  assign fwd_b       = (id_valid && id_rs2_used) ? sel_b : '0;
  assign inflight    = inflight_cnt;
  assign stall_count = stall_count_q;

  always_comb begin
    v_d  = v_q;
    wr_d = wr_q;
    ld_d = ld_q;
    rd_d = rd_q;
    if (!mem_wait) begin
      for (int k = DEPTH; k >= 2; k--) begin
        v_d[k]  = v_q[k-1];
        wr_d[k] = wr_q[k-1];
        ld_d[k] = ld_q[k-1];
        rd_d[k] = rd_q[k-1];
      end
      v_d[1]  = id_valid & ~kill & ~stall;
      wr_d[1] = id_reg_wr;
      ld_d[1] = id_mem_rd;
      rd_d[1] = id_rd;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !mem_wait && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q           <= '0;
      stall_count_q <= '0;
    end else begin
      v_q           <= v_d;
      stall_count_q <= stall_count_d;
    end
    // Payload fields are qualified by v_q, so they need no reset.
    wr_q <= wr_d;
    ld_q <= ld_d;
    rd_q <= rd_d;
  end

endmodule

// File: tb/tb_pipeline_hazard_tracker.sv
// tb/tb_pipeline_hazard_tracker.sv - directed bench for pipeline_hazard_tracker
module tb_pipeline_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_reg_wr, id_mem_rd;
  logic       kill, mem_wait;

  logic        d_stall, d_hold_id;
  logic [1:0]  d_fwd_a, d_fwd_b, d_inflight;
  logic [15:0] d_stall_count;
  logic        z_stall, z_hold_id;
  logic [1:0]  z_fwd_a, z_fwd_b, z_inflight;
  logic [15:0] z_stall_count;
  logic        c_stall, c_hold_id;
  logic [1:0]  c_fwd_a, c_fwd_b, c_inflight;
  logic [1:0]  c_stall_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_hazard_tracker u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
    .kill(kill), .mem_wait(mem_wait),
    .stall(d_stall), .hold_id(d_hold_id), .fwd_a(d_fwd_a), .fwd_b(d_fwd_b),
    .inflight(d_inflight), .stall_count(d_stall_count)
  );

  pipeline_hazard_tracker #(.ZERO_REG_HARD(1)) u_zero (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
    .kill(kill), .mem_wait(mem_wait),
    .stall(z_stall), .hold_id(z_hold_id), .fwd_a(z_fwd_a), .fwd_b(z_fwd_b),
    .inflight(z_inflight), .stall_count(z_stall_count)
  );

  pipeline_hazard_tracker #(.CNT_W(2)) u_cnt2 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
    .kill(kill), .mem_wait(mem_wait),
    .stall(c_stall), .hold_id(c_hold_id), .fwd_a(c_fwd_a), .fwd_b(c_fwd_b),
    .inflight(c_inflight), .stall_count(c_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs1, input logic u1,
                        input logic [2:0] rs2, input logic u2,
                        input logic [2:0] rd, input logic wr, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_wr = wr; id_mem_rd = ld;
    #1;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; kill = 1'b0; mem_wait = 1'b0;
    idle();
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", d_stall, 0);
    chk("rst_hold", d_hold_id, 0);
    chk("rst_fwd_a", d_fwd_a, 0);
    chk("rst_fwd_b", d_fwd_b, 0);
    chk("rst_inflight", d_inflight, 0);
    chk("rst_count", d_stall_count, 0);
    mem_wait = 1'b1; #1;
    chk("rst_hold_memwait", d_hold_id, 1);
    mem_wait = 1'b0; #1;

    // ADD R2 then a non-writing consumer of R2 walking down the pipe
    set_id(1, 0, 0, 0, 0, 2, 1, 0);
    chk("add_stall", d_stall, 0);
    tick();
    set_id(1, 2, 1, 0, 0, 4, 0, 0);
    chk("add_fwd1", d_fwd_a, 1);
    chk("add_infl1", d_inflight, 1);
    tick();
    chk("add_fwd2", d_fwd_a, 2);
    tick();
    chk("add_fwd3", d_fwd_a, 3);
    tick();
    chk("add_fwd0", d_fwd_a, 0);
    chk("add_infl0", d_inflight, 0);

    // LOAD R3 then use as rs2: one stall, then forward from stage 2
    set_id(1, 0, 0, 0, 0, 3, 1, 1);
    chk("ld_nostall", d_stall, 0);
    tick();
    set_id(1, 0, 0, 3, 1, 4, 0, 0);
    chk("lu_stall", d_stall, 1);
    chk("lu_hold", d_hold_id, 1);
    chk("lu_fwd_b1", d_fwd_b, 1);
    chk("lu_count0", d_stall_count, 0);
    tick();
    chk("lu_stall_off", d_stall, 0);
    chk("lu_fwd_b2", d_fwd_b, 2);
    chk("lu_count1", d_stall_count, 1);
    chk("lu_c2_count1", c_stall_count, 1);
    chk("lu_bubble_infl", d_inflight, 1);
    tick();
    idle();
    chk("lu_drain_infl1", d_inflight, 1);
    tick();
    chk("lu_drain_infl0", d_inflight, 0);

    // Same load-use with mem_wait for the first three stall cycles
    set_id(1, 0, 0, 0, 0, 3, 1, 1);
    tick();
    set_id(1, 0, 0, 3, 1, 4, 0, 0);
    mem_wait = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("mw_stall", d_stall, 1);
      chk("mw_fwd_b", d_fwd_b, 1);
      chk("mw_count", d_stall_count, 1);
      tick();
    end
    mem_wait = 1'b0; #1;
    chk("mw_stall4", d_stall, 1);
    tick();
    chk("mw_release", d_stall, 0);
    chk("mw_fwd_b2", d_fwd_b, 2);
    chk("mw_count2", d_stall_count, 2);
    idle();
    tick(); tick(); tick();
    chk("mw_drain", d_inflight, 0);

    // R5 at stage 1 and stage 3: youngest wins
    set_id(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    idle();
    tick();
    set_id(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    set_id(1, 5, 1, 0, 0, 0, 0, 0);
    chk("young_fwd_a", d_fwd_a, 1);
    chk("young_infl", d_inflight, 2);
    chk("young_z_fwd_a", z_fwd_a, 1);
    set_id(1, 5, 0, 0, 0, 0, 0, 0);
    chk("young_unused", d_fwd_a, 0);
    set_id(0, 5, 1, 0, 0, 0, 0, 0);
    chk("young_invalid", d_fwd_a, 0);
    idle();
    tick(); tick(); tick();

    // Load to R0, then use of R0; then kill during the hazard
    set_id(1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    set_id(1, 0, 1, 0, 0, 6, 1, 0);
    chk("r0_stall", d_stall, 1);
    chk("r0_fwd_a", d_fwd_a, 1);
    chk("r0z_stall", z_stall, 0);
    chk("r0z_fwd_a", z_fwd_a, 0);
    chk("r0z_infl", z_inflight, 1);
    kill = 1'b1; #1;
    chk("kill_stall", d_stall, 0);
    chk("kill_hold", d_hold_id, 0);
    tick();
    kill = 1'b0;
    idle();
    chk("kill_no_insert", d_inflight, 1);
    chk("kill_count", d_stall_count, 2);

    // mem_wait together with kill: records hold
    set_id(1, 0, 0, 0, 0, 7, 1, 0);
    kill = 1'b1; mem_wait = 1'b1;
    tick();
    kill = 1'b0; mem_wait = 1'b0;
    set_id(1, 0, 1, 0, 0, 0, 0, 0);
    chk("mwkill_fwd_a", d_fwd_a, 2);
    chk("mwkill_stall", d_stall, 0);
    chk("mwkill_infl", d_inflight, 1);
    idle();
    tick(); tick(); tick();

    // Reset mid-stream
    set_id(1, 0, 0, 0, 0, 1, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 2, 1, 0);
    tick();
    idle();
    chk("pre_rst_infl", d_inflight, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_id(1, 2, 1, 0, 0, 0, 0, 0);
    chk("mid_rst_infl", d_inflight, 0);
    chk("mid_rst_fwd_a", d_fwd_a, 0);
    chk("mid_rst_count", d_stall_count, 0);
    chk("mid_rst_c2_count", c_stall_count, 0);
    idle();

    // Five load-use stalls: narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      set_id(1, 0, 0, 0, 0, 3, 1, 1);
      tick();
      set_id(1, 0, 0, 3, 1, 4, 0, 0);
      chk("sat_stall", d_stall, 1);
      tick();
      tick();
    end
    idle();
    chk("sat_wide_count", d_stall_count, 5);
    chk("sat_c2_count", c_stall_count, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
